// File: rtl/channel_frame_gather.sv
// channel_frame_gather
//   Round-robin frame gatherer between the per-channel peak-data FIFOs and
//   the inter-FPGA communication block. When a channel's FIFO reports full,
//   the block raises a request. After a start grant it reads exactly one
//   FRAME_LEN-word frame from that FIFO, compensates for the FIFO read
//   latency and streams the words out with sof/eof/channel tags.
//
// Ports
//   clk_in      clock
//   rst_n       asynchronous active-low reset
//   fifo_full   per-channel FIFO full flags (bit i = channel i)
//   fifo_data   per-channel read data, channel i at [i*DATA_W +: DATA_W]
//   fifo_rd     per-channel read strobes, one-hot or zero
//   start_in    downstream grant for the pending frame
//   abort_in    downstream cancel of the current frame
//   gather_req  frame pending, waiting for start_in
//   gather_ch   channel of the pending/active frame
//   out_data    frame word (0 when out_valid=0)
//   out_valid   out_data holds a frame word
//   out_sof     first word of frame
//   out_eof     last word of frame
//   busy        high in every state except IDLE
module channel_frame_gather #(
  parameter int NUM_CH    = 6,
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 128,
  parameter int RD_LAT    = 2,
  parameter int CH_W      = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        fifo_full,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]        fifo_rd,
  input  logic                     start_in,
  input  logic                     abort_in,
  output logic                     gather_req,
  output logic [CH_W-1:0]          gather_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     busy
);

  localparam int CNT_W = (FRAME_LEN > 255) ? 9 : 8;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CH_W-1:0]  LAST_CH_RST = CH_W'(NUM_CH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state;
  logic [NUM_CH-1:0] full_q;
  logic [CH_W-1:0]   last_ch;
  logic [CNT_W-1:0]  rd_cnt;

  // Read-latency pipeline: strobe, first-word and last-word tags.
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_f;
  logic [RD_LAT-1:0] pipe_l;

  logic              arb_hit;
  logic [CH_W-1:0]   arb_ch;
  logic [DATA_W-1:0] sel_data;

  // Round-robin search: channels above last_ch first, then wrap to those
  // at or below it. Constant loop bounds keep this a flat priority encoder.
  always_comb begin
    arb_hit = 1'b0;
    arb_ch  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!arb_hit && full_q[c] && (CH_W'(c) > last_ch)) begin
        arb_hit = 1'b1;
        arb_ch  = CH_W'(c);
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!arb_hit && full_q[c] && (CH_W'(c) <= last_ch)) begin
        arb_hit = 1'b1;
        arb_ch  = CH_W'(c);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (gather_ch == CH_W'(c)) begin
        sel_data = fifo_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    fifo_rd = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      fifo_rd[c] = (state == READ) && (gather_ch == CH_W'(c));
    end
  end

  assign gather_req = (state == REQ);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      full_q    <= '0;
      last_ch   <= LAST_CH_RST;
      gather_ch <= '0;
      rd_cnt    <= '0;
      pipe_v    <= '0;
      pipe_f    <= '0;
      pipe_l    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      full_q <= fifo_full;

      pipe_v[0] <= (state == READ);
      pipe_f[0] <= (rd_cnt == '0);
      pipe_l[0] <= (rd_cnt == LAST_CNT);
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_f[k] <= pipe_f[k-1];
        pipe_l[k] <= pipe_l[k-1];
      end

      if (pipe_v[RD_LAT-1]) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sof   <= pipe_f[RD_LAT-1];
        out_eof   <= pipe_l[RD_LAT-1];
      end else begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arb_hit) begin
            gather_ch <= arb_ch;
            state     <= REQ;
          end
        end
        REQ: begin
          if (abort_in) begin
            state <= IDLE;
          end else if (start_in) begin
            state <= READ;
          end
        end
        READ: begin
          if (!abort_in) begin
            if (rd_cnt == LAST_CNT) begin
              rd_cnt <= '0;
              state  <= DRAIN;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!abort_in && out_valid && out_eof) begin
            last_ch <= gather_ch;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort overrides the pipeline and output updates made above, so
      // in-flight words are discarded and no eof is produced.
      if (abort_in && ((state == READ) || (state == DRAIN))) begin
        state     <= IDLE;
        last_ch   <= gather_ch;
        rd_cnt    <= '0;
        pipe_v    <= '0;
        pipe_f    <= '0;
        pipe_l    <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/channel_frame_gather.md
Name: channel_frame_gather

Overview:
Parametrised N-channel frame gatherer that sits between the per-channel peak-data FIFOs and the inter-FPGA communication block. It watches each channel's FIFO-full flag and picks one full channel by round-robin arbitration. After a start handshake from the communication side, it reads exactly one frame of FRAME_LEN words from that FIFO. It compensates for the FIFO read latency and streams the frame out with valid, start-of-frame (sof), end-of-frame (eof) and channel-ID tags. It replaces the single-channel fixed-128-word gather logic.

Parameters:
NUM_CH, 6, number of input channels (2..8)
DATA_W, 16, FIFO data width
FRAME_LEN, 128, words per frame (2..256)
RD_LAT, 2, FIFO read latency in cycles, from rd strobe to data valid (1..4)
CH_W, 3, width of channel index, ≥ clog2(NUM_CH)

Ports:
clk_in  in  1  clock
rst_n  in  1  asynchronous active-low reset
fifo_full  in  NUM_CH  per-channel FIFO full flags; bit i = channel i
fifo_data  in  NUM_CH*DATA_W  per-channel FIFO read data; channel i occupies bits [i*DATA_W +: DATA_W]
fifo_rd  out  NUM_CH  per-channel FIFO read strobes, one-hot or zero
start_in  in  1  downstream grant: begin reading the requested frame
abort_in  in  1  downstream cancel of the current frame
gather_req  out  1  a frame is pending and waiting for start_in
gather_ch  out  CH_W  channel selected for the pending or active frame
out_data  out  DATA_W  frame word; 0 when out_valid=0
out_valid  out  1  out_data holds a frame word
out_sof  out  1  first word of frame (qualified by out_valid)
out_eof  out  1  last word of frame (qualified by out_valid)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk_in. All outputs reset to 0. FSM resets to IDLE, round-robin pointer last_ch resets to NUM_CH-1, all counters reset to 0.
- fifo_full is registered once (full_q) before use.
- FSM states: IDLE, REQ, READ, DRAIN.
- IDLE:
  - If any full_q bit is set, select the first set bit searching upward from last_ch+1, wrapping modulo NUM_CH.
  - Latch the selection into gather_ch and go to REQ.
  - Arbitration takes one cycle.
- REQ:
  - gather_req=1.
  - When start_in=1, go to READ; gather_req drops on the next cycle.
  - The request is committed: if full_q falls while in REQ, the FSM stays in REQ.
- READ:
  - fifo_rd[gather_ch]=1 for exactly FRAME_LEN consecutive cycles. The first strobe is in the cycle after start_in is sampled.
  - An 8-bit read counter rd_cnt counts issued strobes; it is 9 bits when FRAME_LEN=256.
  - After the last strobe, go to DRAIN.
- Capture pipeline:
  - A shift register of RD_LAT stages carries the rd strobe plus first/last tags.
  - When the delayed strobe is high, the next edge registers out_data<=fifo_data slice of gather_ch and sets out_valid=1.
  - Latency: first out_valid occurs RD_LAT+1 cycles after the first fifo_rd cycle.
  - out_valid is continuous for FRAME_LEN cycles, with no gaps.
  - out_sof is high on word 0 only; out_eof is high on word FRAME_LEN-1 only.
- DRAIN:
  - Wait until the eof word has been output.
  - Then update last_ch<=gather_ch and go to IDLE.
  - busy falls in the cycle after eof.
- Back-to-back operation: a new arbitration may start in the first IDLE cycle, using the updated last_ch.
- abort_in in READ or DRAIN:
  - fifo_rd=0 from the next cycle.
  - Pipeline is flushed: out_valid=0, no eof emitted.
  - last_ch is updated and the FSM returns to IDLE.
- abort_in in REQ: drop the request, return to IDLE, last_ch is not updated.
- start_in is ignored outside REQ. abort_in is ignored in IDLE.
- abort_in and start_in high together in REQ: abort wins.
- fifo_rd bits for unselected channels are always 0. More than one fifo_rd bit high at once is an error.

Test Plan:
- Single channel: NUM_CH=6, RD_LAT=2, set fifo_full[2], pulse start_in → gather_ch=2; exactly 128 fifo_rd[2] pulses; out_valid for 128 consecutive cycles starting 3 cycles after the first rd; sof on word 0, eof on word 127; data matches the FIFO model.
- Round-robin: full[1], full[4] and full[5] held high, start_in granted immediately each time → frames served in order 1,4,5,1; after reset the first frame is channel 0 when all channels are full.
- Latency sweep: RD_LAT=1 and RD_LAT=4, FRAME_LEN=2 and FRAME_LEN=256 → first valid at RD_LAT+1 cycles after the first rd; word count exact; sof and eof both correct for the 2-word frame.
- Abort: abort_in at read word 50 → fifo_rd low the next cycle; out_valid low after flush; no eof; next frame goes to the following channel in round-robin order.
- Handshake edges: full drops while in REQ → request held; start_in and abort_in asserted together in REQ → IDLE with no reads; start_in in IDLE → no effect.
- Reset mid-frame: assert rst_n low during READ → all outputs 0 immediately; after release, arbitration restarts from channel 0.
